// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - AXI4-Lite response codes and elaboration helpers
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/axil_bytewise_ram.sv
// rtl/axil_bytewise_ram.sv - word array with per-byte write enables, read-before-write
module axil_bytewise_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rd_en,
    input  logic [IDX_WIDTH-1:0]    rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    wr_en,
    input  logic [IDX_WIDTH-1:0]    wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports use nonblocking updates, so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
        if (wr_en) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axil_ram_ctrl.sv
// rtl/axil_ram_ctrl.sv - AXI4-Lite slave RAM; AXIL_RAM_ERR_EN selects SLVERR vs index wrap
module axil_ram_ctrl
    import axil_pkg::*;
#(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int MEM_DEPTH       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arvalid,
    input  logic [AXIL_ADDR_WIDTH-1:0]   araddr,
    output logic                         arready,
    output logic                         rvalid,
    output logic [AXIL_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                   rresp,
    input  logic                         rready,
    input  logic                         awvalid,
    input  logic [AXIL_ADDR_WIDTH-1:0]   awaddr,
    output logic                         awready,
    input  logic                         wvalid,
    input  logic [AXIL_DATA_WIDTH-1:0]   wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
    output logic                         wready,
    output logic                         bvalid,
    output logic [1:0]                   bresp,
    input  logic                         bready
);

    localparam int STRB_W   = AXIL_DATA_WIDTH / 8;
    localparam int ADDR_LSB = clog2(STRB_W);
    localparam int IDX_W    = AXIL_ADDR_WIDTH - ADDR_LSB;
    localparam int RAM_AW   = (MEM_DEPTH > 1) ? clog2(MEM_DEPTH) : 1;

    logic [IDX_W-1:0]           ar_idx, ar_word, aw_idx_q, wr_word;
    logic                       rd_err, wr_err;
    logic                       aw_full, w_full, rd_zero;
    logic [AXIL_DATA_WIDTH-1:0] w_data_q, ram_q;
    logic [STRB_W-1:0]          w_strb_q;
    logic                       ar_hs, aw_hs, w_hs, commit;
    logic                       unused_bits;

    assign ar_idx = araddr[AXIL_ADDR_WIDTH-1:ADDR_LSB];

`ifdef AXIL_RAM_ERR_EN
    assign ar_word = ar_idx;
    assign wr_word = aw_idx_q;
    assign rd_err  = {1'b0, ar_idx} >= (IDX_W+1)'(MEM_DEPTH);
    assign wr_err  = {1'b0, aw_idx_q} >= (IDX_W+1)'(MEM_DEPTH);
`else
    if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_depth_check
        $error("MEM_DEPTH must be a power of two when index wrapping is used");
    end
    assign ar_word = ar_idx & IDX_W'(MEM_DEPTH - 1);
    assign wr_word = aw_idx_q & IDX_W'(MEM_DEPTH - 1);
    assign rd_err  = 1'b0;
    assign wr_err  = 1'b0;
`endif

    assign unused_bits = ^{araddr, awaddr, ar_word, wr_word};

    assign arready = !reset && (!rvalid || rready);
    assign awready = !reset && !aw_full;
    assign wready  = !reset && !w_full;
    assign ar_hs   = arvalid && arready;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign commit  = !reset && aw_full && w_full && (!bvalid || bready);

    // rdata is forced to zero after reset and for rejected reads; the RAM output is not reset.
    assign rdata = rd_zero ? '0 : ram_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rd_zero <= 1'b1;
        end else if (ar_hs) begin
            rvalid  <= 1'b1;
            rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rd_zero <= rd_err;
        end else if (rready) begin
            rvalid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full  <= 1'b1;
                aw_idx_q <= awaddr[AXIL_ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (bready) begin
            bvalid <= 1'b0;
        end
    end

    axil_bytewise_ram #(
        .DATA_WIDTH (AXIL_DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_WIDTH  (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ar_hs && !rd_err),
        .rd_idx  (RAM_AW'(ar_word)),
        .rd_data (ram_q),
        .wr_en   (commit && !wr_err),
        .wr_idx  (RAM_AW'(wr_word)),
        .wr_data (w_data_q),
        .wr_strb (w_strb_q)
    );

endmodule

// File: tb/tb_axil_ram_ctrl.sv
// tb/tb_axil_ram_ctrl.sv - scoreboard bench for axil_ram_ctrl
module tb_axil_ram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arvalid = 0, arready, rvalid, rready = 0;
    logic [AW-1:0] araddr = '0, awaddr = '0;
    logic [DW-1:0] rdata, wdata = '0;
    logic [1:0]    rresp, bresp;
    logic          awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic [3:0]    wstrb = '0;

    always #5 clk = ~clk;

    axil_ram_ctrl #(.AXIL_DATA_WIDTH(DW), .AXIL_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } resp_t;

    resp_t       rq[$];
    resp_t       bq[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          fails  = 0;
    bit          rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic resp_t model_read(input logic [7:0] a);
        resp_t r;
        int idx;
        idx = int'(a) / 4;
`ifdef AXIL_RAM_ERR_EN
        if (idx >= DEPTH) begin
            r.data = 32'h0;
            r.resp = 2'b10;
            return r;
        end
`endif
        r.data = model[idx % DEPTH];
        r.resp = 2'b00;
        return r;
    endfunction

    function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
`ifdef AXIL_RAM_ERR_EN
        if (idx >= DEPTH) return 2'b10;
`endif
        for (int b = 0; b < 4; b++)
            if (s[b]) model[idx % DEPTH][b*8 +: 8] = d[b*8 +: 8];
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        resp_t e;
        if (!reset && rvalid && rready) begin
            if (rq.size() == 0) check("r_unexpected", 1, 0);
            else begin
                e = rq.pop_front();
                check("rdata", rdata, e.data);
                check("rresp", rresp, e.resp);
            end
        end
    end

    always @(negedge clk) begin
        resp_t e;
        if (!reset && bvalid && bready) begin
            if (bq.size() == 0) check("b_unexpected", 1, 0);
            else begin
                e = bq.pop_front();
                check("bresp", bresp, e.resp);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            rready = 1'($urandom);
            bready = 1'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [7:0] a);
        bit hs;
        int n = 0;
        arvalid = 1; araddr = a;
        forever begin
            @(negedge clk); hs = arready;
            tick();
            if (hs) break;
            if (++n > 100) begin check("ar_timeout", 0, 1); break; end
        end
        arvalid = 0;
    endtask

    task automatic send_aw(input logic [7:0] a);
        bit hs;
        int n = 0;
        awvalid = 1; awaddr = a;
        forever begin
            @(negedge clk); hs = awready;
            tick();
            if (hs) break;
            if (++n > 100) begin check("aw_timeout", 0, 1); break; end
        end
        awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit hs;
        int n = 0;
        wvalid = 1; wdata = d; wstrb = s;
        forever begin
            @(negedge clk); hs = wready;
            tick();
            if (hs) break;
            if (++n > 100) begin check("w_timeout", 0, 1); break; end
        end
        wvalid = 0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        resp_t e;
        int aw_delay, w_delay;
        e.data = 0;
        e.resp = model_write(a, d, s);
        bq.push_back(e);
        aw_delay = (lead > 0) ? lead : 0;
        w_delay  = (lead < 0) ? -lead : 0;
        fork
            begin repeat (aw_delay) tick(); send_aw(a); end
            begin repeat (w_delay) tick(); send_w(d, s); end
        join
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
        resp_t e;
        e.data = d;
        e.resp = r;
        rq.push_back(e);
        send_ar(a);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin tick(); n++; end
        if (n >= 300) check("drain_timeout", 0, 1);
    endtask

    task automatic wait_bvalid();
        int n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        check("bvalid_wait", bvalid, 1);
    endtask

    initial begin
        resp_t e;
        logic [31:0] d;
        logic [7:0]  a;
        int          lead;

        repeat (3) tick();
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resps", {rresp, bresp}, 0);
        check("rst_readies", {arready, awready, wready}, 0);
        reset = 0;
        rready = 1; bready = 1;

        for (int i = 0; i < DEPTH; i++)
            do_write(8'(i * 4), (i == 3) ? 32'hFFFF_FFFF : $urandom, 4'hF, 0);
        wait_drain();

        // AW+W together: captured at edge N, B visible after N+1
        bq.push_back('{data: 0, resp: model_write(8'h08, 32'hDEAD_BEEF, 4'hF)});
        awvalid = 1; awaddr = 8'h08; wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        @(negedge clk);
        check("aw_w_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 0; wvalid = 0;
        check("bvalid_edge_n", bvalid, 0);
        tick();
        check("bvalid_edge_n1", bvalid, 1);
        wait_drain();
        rq.push_back('{data: 32'hDEAD_BEEF, resp: 2'b00});
        arvalid = 1; araddr = 8'h08;
        tick();
        arvalid = 0;
        check("rvalid_latency", rvalid, 1);
        check("rdata_latency", rdata, 32'hDEAD_BEEF);
        wait_drain();

        // W three cycles ahead of AW, partial strobes
        bq.push_back('{data: 0, resp: model_write(8'h0C, 32'h1122_3344, 4'h5)});
        send_w(32'h1122_3344, 4'h5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wready_buffered", wready, 0);
            tick();
        end
        send_aw(8'h0C);
        wait_drain();
        do_read(8'h0C, 32'hFF22_FF44, 2'b00);
        wait_drain();

        // index 16: SLVERR or wrap onto index 0
        d = model[0];
        do_write(8'h40, 32'hCAFE_F00D, 4'hF, 0);
        wait_drain();
`ifdef AXIL_RAM_ERR_EN
        do_read(8'h40, 32'h0, 2'b10);
        do_read(8'h00, d, 2'b00);
`else
        do_read(8'h40, 32'hCAFE_F00D, 2'b00);
        do_read(8'h00, 32'hCAFE_F00D, 2'b00);
`endif
        wait_drain();

        // rready held low: rvalid/rdata stable, arready low
        rready = 0;
        do_read(8'h08, 32'hDEAD_BEEF, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rvalid", rvalid, 1);
            check("hold_rdata", rdata, 32'hDEAD_BEEF);
            check("hold_arready", arready, 0);
            tick();
        end
        rready = 1;
        wait_drain();
        e = model_read(8'h00); do_read(8'h00, e.data, e.resp);
        e = model_read(8'h04); do_read(8'h04, e.data, e.resp);
        check("b2b_rvalid0", rvalid, 1);
        e = model_read(8'h08); do_read(8'h08, e.data, e.resp);
        check("b2b_rvalid1", rvalid, 1);
        wait_drain();

        // bready low while a second pair is buffered
        bready = 0;
        do_write(8'h10, 32'hA1A2_A3A4, 4'hF, 0);
        wait_bvalid();
        do_write(8'h14, 32'hB1B2_B3B4, 4'hF, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_readies", {awready, wready}, 2'b00);
            check("stall_bvalid", bvalid, 1);
            tick();
        end
        bready = 1;
        tick();
        check("second_commit_bvalid", bvalid, 1);
        tick();
        check("bvalid_cleared", bvalid, 0);
        wait_drain();

        // reset with an AW buffered and a B pending
        bready = 0;
        do_write(8'h18, 32'h5A5A_5A5A, 4'hF, 0);
        wait_bvalid();
        send_aw(8'h1C);
        reset = 1;
        #1;
        check("rst_mid_bvalid", bvalid, 0);
        check("rst_mid_readies", {arready, awready, wready}, 0);
        bq.delete();
        tick(); tick();
        reset = 0;
        bready = 1;
        @(negedge clk);
        check("post_rst_readies", {arready, awready, wready}, 3'b111);
        tick();
        do_read(8'h18, 32'h5A5A_5A5A, 2'b00);
        e = model_read(8'h1C); do_read(8'h1C, e.data, e.resp);
        wait_drain();

        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                a = 8'($urandom_range(0, 127));
                lead = int'($urandom_range(0, 4)) - 2;
                do_write(a, $urandom, 4'($urandom), lead);
            end else begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    a = 8'($urandom_range(0, 127));
                    e = model_read(a);
                    do_read(a, e.data, e.resp);
                end
            end
            wait_drain();
        end
        rand_ready = 0;
        @(posedge clk); #2;
        rready = 1; bready = 1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
